// File: rtl/fewcore_pkg.sv
// Shared fewcore pipeline types: forward-select encodings and hazard tracking entry.
package fewcore_pkg;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       is_load;
    } trk_entry_t;

    localparam trk_entry_t TRK_BUBBLE = '0;

    // True when a tracked instruction will produce the value of source register rs.
    function automatic logic trk_hits(input trk_entry_t e, input logic [4:0] rs);
        return e.valid & e.reg_write & (e.rd == rs) & (rs != REG_X0);
    endfunction

endpackage

// File: rtl/hazard_fwd_cmp.sv
// Forward-select compare of one ID source register against the EX and MEM tracking entries.
module hazard_fwd_cmp
    import fewcore_pkg::*;
(
    input  logic       i_use,
    input  logic [4:0] i_rs,
    input  trk_entry_t i_ex,
    input  trk_entry_t i_mem,
    output logic [1:0] o_sel
);

    logic w_unused_load;
    assign w_unused_load = i_ex.is_load ^ i_mem.is_load;

    // The younger producer (EX) wins over the older one (MEM).
    always_comb begin
        o_sel = FWD_RF;
        if (i_use && trk_hits(i_ex, i_rs)) begin
            o_sel = FWD_EXMEM;
        end else if (i_use && trk_hits(i_mem, i_rs)) begin
            o_sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// fewcore execute-stage hazard controller: registered forwarding selects, load-use stall,
// multi-cycle flush on taken branches. Define HAZARD_PERF_EN to build stall/flush counters.
module hazard_ctrl
    import fewcore_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [4:0]      id_rd,
    input  logic            id_reg_write,
    input  logic            id_is_load,
    input  logic            ex_branch_taken,
    output logic [1:0]      fwd_rs1,
    output logic [1:0]      fwd_rs2,
    output logic            stall,
    output logic            flush,
    output logic [XLEN-1:0] perf_stall_cnt,
    output logic [XLEN-1:0] perf_flush_cnt
);

    trk_entry_t r_ex, r_mem, r_wb;
    trk_entry_t w_id_entry;
    logic [2:0] r_flush_cnt;
    logic [1:0] r_fwd_rs1, r_fwd_rs2;
    logic [1:0] w_sel_rs1, w_sel_rs2;
    logic       w_load_use, w_flush, w_stall, w_issue;
    logic       w_unused_wb;

    assign w_unused_wb = ^r_wb;

    hazard_fwd_cmp u_cmp_rs1 (
        .i_use (id_use_rs1),
        .i_rs  (id_rs1),
        .i_ex  (r_ex),
        .i_mem (r_mem),
        .o_sel (w_sel_rs1)
    );

    hazard_fwd_cmp u_cmp_rs2 (
        .i_use (id_use_rs2),
        .i_rs  (id_rs2),
        .i_ex  (r_ex),
        .i_mem (r_mem),
        .o_sel (w_sel_rs2)
    );

    assign w_id_entry = '{valid: 1'b1, rd: id_rd, reg_write: id_reg_write, is_load: id_is_load};

    assign w_load_use = id_valid & r_ex.is_load &
                        ((id_use_rs1 & trk_hits(r_ex, id_rs1)) |
                         (id_use_rs2 & trk_hits(r_ex, id_rs2)));
    assign w_flush    = ex_branch_taken | (r_flush_cnt != '0);
    assign w_stall    = w_load_use & ~w_flush;
    assign w_issue    = id_valid & ~w_stall & ~w_flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ex        <= TRK_BUBBLE;
            r_mem       <= TRK_BUBBLE;
            r_wb        <= TRK_BUBBLE;
            r_fwd_rs1   <= FWD_RF;
            r_fwd_rs2   <= FWD_RF;
            r_flush_cnt <= '0;
        end else begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            if (w_issue) begin
                r_ex      <= w_id_entry;
                r_fwd_rs1 <= w_sel_rs1;
                r_fwd_rs2 <= w_sel_rs2;
            end else begin
                r_ex      <= TRK_BUBBLE;
                r_fwd_rs1 <= FWD_RF;
                r_fwd_rs2 <= FWD_RF;
            end
            // A new taken branch restarts the tail rather than extending it.
            if (ex_branch_taken) begin
                r_flush_cnt <= 3'(FLUSH_CYCLES - 1);
            end else if (r_flush_cnt != '0) begin
                r_flush_cnt <= r_flush_cnt - 3'd1;
            end
        end
    end

    assign fwd_rs1 = r_fwd_rs1;
    assign fwd_rs2 = r_fwd_rs2;
    assign stall   = w_stall;
    assign flush   = w_flush;

`ifdef HAZARD_PERF_EN
    logic [XLEN-1:0] r_perf_stall, r_perf_flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
        end else begin
            if (w_stall && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + 1'b1;
            if (w_flush && (r_perf_flush != '1)) r_perf_flush <= r_perf_flush + 1'b1;
        end
    end

    assign perf_stall_cnt = r_perf_stall;
    assign perf_flush_cnt = r_perf_flush;
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use stall, flush, reset.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_is_load, ex_branch_taken;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [1:0]  fwd_rs1, fwd_rs2;
    logic        stall, flush;
    logic [31:0] perf_stall_cnt, perf_flush_cnt;

    int n_vec = 0;
    int n_err = 0;

`ifdef HAZARD_PERF_EN
    logic [31:0] exp_pstall = 32'd1;
    logic [31:0] exp_pflush = 32'd8;
`else
    logic [31:0] exp_pstall = 32'd0;
    logic [31:0] exp_pflush = 32'd0;
`endif

    hazard_ctrl #(.XLEN(32), .FLUSH_CYCLES(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .id_rd           (id_rd),
        .id_reg_write    (id_reg_write),
        .id_is_load      (id_is_load),
        .ex_branch_taken (ex_branch_taken),
        .fwd_rs1         (fwd_rs1),
        .fwd_rs2         (fwd_rs2),
        .stall           (stall),
        .flush           (flush),
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_flush_cnt  (perf_flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic rw, input logic ld, input logic br);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        id_rd = rd; id_reg_write = rw; id_is_load = ld; ex_branch_taken = br;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        n_vec++; if (fwd_rs1 !== 2'b00) begin n_err++; $display("FAIL rst_fwd_rs1: got %b want 00", fwd_rs1); end
        n_vec++; if (fwd_rs2 !== 2'b00) begin n_err++; $display("FAIL rst_fwd_rs2: got %b want 00", fwd_rs2); end
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %b want 0", stall); end
        n_vec++; if (flush !== 1'b0) begin n_err++; $display("FAIL rst_flush: got %b want 0", flush); end
        n_vec++; if (perf_flush_cnt !== 32'd0) begin n_err++; $display("FAIL rst_pflush: got %0d want 0", perf_flush_cnt); end
        reset = 1'b1;
        clear();
    endtask

    task automatic test_fwd_exmem();
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
        tick();
        drive(1, 5, 6, 1, 1, 8, 1, 0, 0);
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL t1_stall: got %b want 0", stall); end
        tick();
        n_vec++; if (fwd_rs1 !== 2'b01) begin n_err++; $display("FAIL t1_fwd_rs1: got %b want 01", fwd_rs1); end
        n_vec++; if (fwd_rs2 !== 2'b00) begin n_err++; $display("FAIL t1_fwd_rs2: got %b want 00", fwd_rs2); end
        clear();
        // use bit gates forwarding
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
        tick();
        drive(1, 5, 5, 0, 1, 8, 1, 0, 0);
        tick();
        n_vec++; if (fwd_rs1 !== 2'b00) begin n_err++; $display("FAIL t1_nouse_rs1: got %b want 00", fwd_rs1); end
        n_vec++; if (fwd_rs2 !== 2'b01) begin n_err++; $display("FAIL t1_nouse_rs2: got %b want 01", fwd_rs2); end
        clear();
    endtask

    task automatic test_fwd_memwb();
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
        tick();
        drive(1, 1, 2, 1, 1, 9, 1, 0, 0);
        tick();
        n_vec++; if (fwd_rs1 !== 2'b00) begin n_err++; $display("FAIL t2_indep_rs1: got %b want 00", fwd_rs1); end
        drive(1, 3, 5, 1, 1, 10, 1, 0, 0);
        tick();
        n_vec++; if (fwd_rs2 !== 2'b10) begin n_err++; $display("FAIL t2_fwd_rs2: got %b want 10", fwd_rs2); end
        n_vec++; if (fwd_rs1 !== 2'b00) begin n_err++; $display("FAIL t2_fwd_rs1: got %b want 00", fwd_rs1); end
        clear();
        // EX producer beats MEM producer of the same register
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
        tick();
        drive(1, 1, 0, 1, 0, 5, 1, 0, 0);
        tick();
        drive(1, 5, 5, 1, 1, 10, 1, 0, 0);
        tick();
        n_vec++; if (fwd_rs1 !== 2'b01) begin n_err++; $display("FAIL t2_prio_rs1: got %b want 01", fwd_rs1); end
        n_vec++; if (fwd_rs2 !== 2'b01) begin n_err++; $display("FAIL t2_prio_rs2: got %b want 01", fwd_rs2); end
        clear();
    endtask

    task automatic test_x0();
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        drive(1, 1, 2, 1, 1, 9, 1, 0, 0);
        tick();
        drive(1, 0, 0, 1, 1, 0, 1, 0, 0);
        tick();
        n_vec++; if (fwd_rs1 !== 2'b00) begin n_err++; $display("FAIL t3_mem_rs1: got %b want 00", fwd_rs1); end
        n_vec++; if (fwd_rs2 !== 2'b00) begin n_err++; $display("FAIL t3_mem_rs2: got %b want 00", fwd_rs2); end
        drive(1, 0, 0, 1, 1, 0, 1, 0, 0);
        tick();
        n_vec++; if (fwd_rs1 !== 2'b00) begin n_err++; $display("FAIL t3_ex_rs1: got %b want 00", fwd_rs1); end
        n_vec++; if (fwd_rs2 !== 2'b00) begin n_err++; $display("FAIL t3_ex_rs2: got %b want 00", fwd_rs2); end
        clear();
        drive(1, 0, 0, 0, 0, 0, 1, 1, 0);
        tick();
        drive(1, 0, 0, 1, 1, 4, 1, 0, 0);
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL t3_ld_stall: got %b want 0", stall); end
        clear();
    endtask

    task automatic test_load_use();
        drive(1, 0, 0, 0, 0, 7, 1, 1, 0);
        tick();
        drive(1, 7, 2, 1, 1, 10, 1, 0, 0);
        n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL t4_stall_on: got %b want 1", stall); end
        tick();
        n_vec++; if (fwd_rs1 !== 2'b00) begin n_err++; $display("FAIL t4_bubble_rs1: got %b want 00", fwd_rs1); end
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL t4_stall_off: got %b want 0", stall); end
        tick();
        n_vec++; if (fwd_rs1 !== 2'b10) begin n_err++; $display("FAIL t4_fwd_rs1: got %b want 10", fwd_rs1); end
        n_vec++; if (fwd_rs2 !== 2'b00) begin n_err++; $display("FAIL t4_fwd_rs2: got %b want 00", fwd_rs2); end
        clear();
    endtask

    task automatic test_flush();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        n_vec++; if (flush !== 1'b1) begin n_err++; $display("FAIL t5_flush_c0: got %b want 1", flush); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        n_vec++; if (flush !== 1'b1) begin n_err++; $display("FAIL t5_flush_c1: got %b want 1", flush); end
        tick();
        n_vec++; if (flush !== 1'b0) begin n_err++; $display("FAIL t5_flush_c2: got %b want 0", flush); end
        clear();
    endtask

    task automatic test_reload();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        n_vec++; if (flush !== 1'b1) begin n_err++; $display("FAIL t6_flush_tail: got %b want 1", flush); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        n_vec++; if (flush !== 1'b1) begin n_err++; $display("FAIL t6_flush_reload: got %b want 1", flush); end
        tick();
        n_vec++; if (flush !== 1'b0) begin n_err++; $display("FAIL t6_flush_end: got %b want 0", flush); end
        clear();
    endtask

    task automatic test_stall_flush();
        drive(1, 0, 0, 0, 0, 7, 1, 1, 0);
        tick();
        drive(1, 7, 0, 1, 0, 11, 1, 0, 1);
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL t7_stall: got %b want 0", stall); end
        n_vec++; if (flush !== 1'b1) begin n_err++; $display("FAIL t7_flush: got %b want 1", flush); end
        tick();
        n_vec++; if (fwd_rs1 !== 2'b00) begin n_err++; $display("FAIL t7_bubble_rs1: got %b want 00", fwd_rs1); end
        drive(1, 11, 0, 1, 0, 12, 1, 0, 0);
        n_vec++; if (flush !== 1'b1) begin n_err++; $display("FAIL t7_flush_tail: got %b want 1", flush); end
        tick();
        n_vec++; if (fwd_rs1 !== 2'b00) begin n_err++; $display("FAIL t7_bubble2_rs1: got %b want 00", fwd_rs1); end
        n_vec++; if (flush !== 1'b0) begin n_err++; $display("FAIL t7_flush_end: got %b want 0", flush); end
        clear();
    endtask

    task automatic test_reset_mid();
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        n_vec++; if (flush !== 1'b1) begin n_err++; $display("FAIL t8_pre_flush: got %b want 1", flush); end
        n_vec++; if (perf_stall_cnt !== exp_pstall) begin n_err++; $display("FAIL t8_pstall: got %0d want %0d", perf_stall_cnt, exp_pstall); end
        n_vec++; if (perf_flush_cnt !== exp_pflush) begin n_err++; $display("FAIL t8_pflush: got %0d want %0d", perf_flush_cnt, exp_pflush); end
        #1 reset = 1'b0;
        #1;
        n_vec++; if (flush !== 1'b0) begin n_err++; $display("FAIL t8_rst_flush: got %b want 0", flush); end
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL t8_rst_stall: got %b want 0", stall); end
        n_vec++; if (fwd_rs1 !== 2'b00) begin n_err++; $display("FAIL t8_rst_fwd_rs1: got %b want 00", fwd_rs1); end
        n_vec++; if (perf_stall_cnt !== 32'd0) begin n_err++; $display("FAIL t8_rst_pstall: got %0d want 0", perf_stall_cnt); end
        n_vec++; if (perf_flush_cnt !== 32'd0) begin n_err++; $display("FAIL t8_rst_pflush: got %0d want 0", perf_flush_cnt); end
        #1 reset = 1'b1;
        drive(1, 5, 0, 1, 0, 6, 1, 0, 0);
        n_vec++; if (flush !== 1'b0) begin n_err++; $display("FAIL t8_rel_flush: got %b want 0", flush); end
        tick();
        n_vec++; if (fwd_rs1 !== 2'b00) begin n_err++; $display("FAIL t8_rel_fwd_rs1: got %b want 00", fwd_rs1); end
        n_vec++; if (flush !== 1'b0) begin n_err++; $display("FAIL t8_rel_flush2: got %b want 0", flush); end
        clear();
    endtask

    initial begin
        #1;
        test_reset();
        test_fwd_exmem();
        test_fwd_memwb();
        test_x0();
        test_load_use();
        test_flush();
        test_reload();
        test_stall_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
